// File: rtl/pipe_monitor_dump.sv
// ---------------------------------------------------------------------------
// pipe_monitor_dump
//   End-of-program monitor for the pipelined MIPS core. While the program
//   runs it counts cycles and hazard events. Once the fetch PC reaches END_PC
//   it requests a core halt, then streams a window of data memory out over a
//   valid/ready interface so a bench or UART can read results directly.
//
//   Optional feature macro: PIPE_MON_PERF_EN
//     defined   -> the four saturating performance counters are built
//     undefined -> counter outputs are tied to zero and no counter flops exist
//
// Ports:
//   clk          core clock, rising edge
//   reset        asynchronous active-low reset
//   pc           fetch-stage byte PC
//   stallf       fetch stall from hazard unit
//   flushe       execute flush from hazard unit
//   branchstall  branch-compare stall from hazard unit
//   halt_req     core freeze request, sticky until reset
//   mem_rd_en    data-memory read strobe, one-cycle pulse per word
//   mem_rd_addr  data-memory word address (DUMP_BASE + index)
//   mem_rd_data  read data, valid one cycle after mem_rd_en
//   dump_valid   dump word available
//   dump_ready   consumer accepts the word
//   dump_index   offset of the current word
//   dump_data    current word
//   done         dump complete, sticky until reset
//   cyc_cnt      cycles spent running
//   stall_cnt    running cycles with stallf high
//   flush_cnt    running cycles with flushe high
//   bstall_cnt   running cycles with branchstall high
// ---------------------------------------------------------------------------
module pipe_monitor_dump #(
  parameter logic [31:0] END_PC     = 32'd52,
  parameter int unsigned DUMP_BASE  = 16,
  parameter int unsigned DUMP_COUNT = 15,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc,
  input  logic              stallf,
  input  logic              flushe,
  input  logic              branchstall,
  output logic              halt_req,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [7:0]        dump_index,
  output logic [DATA_W-1:0] dump_data,
  output logic              done,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  bstall_cnt
);

  typedef enum logic [2:0] {
    S_RUN,
    S_REQ,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  // Index of the final word; only meaningful when DUMP_COUNT > 0.
  localparam int unsigned LAST_IDX = (DUMP_COUNT == 0) ? 0 : DUMP_COUNT - 1;

  state_t              r_state;
  logic [7:0]          r_idx;
  logic                r_halt_req;
  logic                r_mem_rd_en;
  logic [ADDR_W-1:0]   r_mem_rd_addr;
  logic                r_dump_valid;
  logic [DATA_W-1:0]   r_dump_data;
  logic                r_done;
  logic                w_end_hit;
  logic                w_last_word;

  assign w_end_hit   = (pc >= END_PC);
  assign w_last_word = (r_idx == 8'(LAST_IDX));

  // Outputs are registered: mem_rd_en is high exactly while in REQ and
  // dump_valid exactly while in SEND, so they are set on the transition in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_RUN;
      r_idx         <= '0;
      r_halt_req    <= 1'b0;
      r_mem_rd_en   <= 1'b0;
      r_mem_rd_addr <= '0;
      r_dump_valid  <= 1'b0;
      r_dump_data   <= '0;
      r_done        <= 1'b0;
    end else begin
      r_mem_rd_en <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (w_end_hit) begin
            r_halt_req <= 1'b1;
            if (DUMP_COUNT > 0) begin
              r_state       <= S_REQ;
              r_mem_rd_en   <= 1'b1;
              r_mem_rd_addr <= ADDR_W'(DUMP_BASE);
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_REQ: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_dump_data  <= mem_rd_data;
          r_dump_valid <= 1'b1;
          r_state      <= S_SEND;
        end
        S_SEND: begin
          if (dump_ready) begin
            r_dump_valid <= 1'b0;
            if (w_last_word) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_idx         <= r_idx + 8'd1;
              // Address wraps modulo 2^ADDR_W by truncation.
              r_mem_rd_addr <= ADDR_W'(DUMP_BASE + 32'(r_idx) + 32'd1);
              r_mem_rd_en   <= 1'b1;
              r_state       <= S_REQ;
            end
          end
        end
        S_DONE: begin
          r_done     <= 1'b1;
          r_halt_req <= 1'b1;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign halt_req    = r_halt_req;
  assign mem_rd_en   = r_mem_rd_en;
  assign mem_rd_addr = r_mem_rd_addr;
  assign dump_valid  = r_dump_valid;
  assign dump_index  = r_idx;
  assign dump_data   = r_dump_data;
  assign done        = r_done;

`ifdef PIPE_MON_PERF_EN
  logic [CNT_W-1:0] r_cyc_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_bstall_cnt;

  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // Counting stops as soon as the FSM leaves RUN, which leaves the
  // detect cycle itself included.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cyc_cnt    <= '0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_bstall_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_cyc_cnt    <= f_sat_inc(r_cyc_cnt, 1'b1);
      r_stall_cnt  <= f_sat_inc(r_stall_cnt, stallf);
      r_flush_cnt  <= f_sat_inc(r_flush_cnt, flushe);
      r_bstall_cnt <= f_sat_inc(r_bstall_cnt, branchstall);
    end
  end

  assign cyc_cnt    = r_cyc_cnt;
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;
  assign bstall_cnt = r_bstall_cnt;
`else
  logic w_unused_hazard;
  assign w_unused_hazard = ^{stallf, flushe, branchstall};

  assign cyc_cnt    = '0;
  assign stall_cnt  = '0;
  assign flush_cnt  = '0;
  assign bstall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_monitor_dump.sv
// ---------------------------------------------------------------------------
// tb_pipe_monitor_dump
//   Directed bench for pipe_monitor_dump. A default-parameter instance runs a
//   short program, dumps 15 words from a modelled RAM (RAM[16+k] = k*k+1),
//   exercises back-pressure and a mid-dump reset. A second instance with
//   DUMP_COUNT=0 and CNT_W=4 covers the empty dump and counter saturation.
//   Counter expectations follow the PIPE_MON_PERF_EN build option.
// ---------------------------------------------------------------------------
module tb_pipe_monitor_dump;

`ifdef PIPE_MON_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        stallf, flushe, branchstall;
  logic        halt_req, mem_rd_en, dump_valid, dump_ready, done;
  logic [7:0]  mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic [7:0]  dump_index;
  logic [31:0] dump_data;
  logic [31:0] cyc_cnt, stall_cnt, flush_cnt, bstall_cnt;

  logic        reset0;
  logic [31:0] pc0;
  logic        halt_req0, mem_rd_en0, dump_valid0, done0;
  logic [7:0]  mem_rd_addr0;
  logic [31:0] mem_rd_data0;
  logic [7:0]  dump_index0;
  logic [31:0] dump_data0;
  logic [3:0]  cyc_cnt0, stall_cnt0, flush_cnt0, bstall_cnt0;
  logic        saw_rd0, saw_valid0;

  logic [31:0] ram [256];
  logic [39:0] exp_q [$];
  logic [7:0]  addr_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  pipe_monitor_dump #(
    .END_PC(32'd52), .DUMP_BASE(16), .DUMP_COUNT(15),
    .DATA_W(32), .ADDR_W(8), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .pc(pc),
    .stallf(stallf), .flushe(flushe), .branchstall(branchstall),
    .halt_req(halt_req), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_index(dump_index), .dump_data(dump_data), .done(done),
    .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .bstall_cnt(bstall_cnt)
  );

  pipe_monitor_dump #(
    .END_PC(32'd52), .DUMP_BASE(16), .DUMP_COUNT(0),
    .DATA_W(32), .ADDR_W(8), .CNT_W(4)
  ) dut0 (
    .clk(clk), .reset(reset0), .pc(pc0),
    .stallf(1'b0), .flushe(1'b0), .branchstall(1'b0),
    .halt_req(halt_req0), .mem_rd_en(mem_rd_en0), .mem_rd_addr(mem_rd_addr0),
    .mem_rd_data(mem_rd_data0), .dump_valid(dump_valid0), .dump_ready(1'b1),
    .dump_index(dump_index0), .dump_data(dump_data0), .done(done0),
    .cyc_cnt(cyc_cnt0), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0),
    .bstall_cnt(bstall_cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read data memory: data valid one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
  end

  always @(posedge clk) begin
    if (mem_rd_en0)  saw_rd0    <= 1'b1;
    if (dump_valid0) saw_valid0 <= 1'b1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [39:0] e;
    int          pulses;
    bit          held;
    bit          found;

    reset = 1'b0; reset0 = 1'b0;
    pc = '0; pc0 = '0;
    stallf = 1'b0; flushe = 1'b0; branchstall = 1'b0;
    dump_ready = 1'b0;
    mem_rd_data = '0; mem_rd_data0 = '0;
    saw_rd0 = 1'b0; saw_valid0 = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = 32'hDEAD_0000 | 32'(i);
    for (int k = 0; k < 15; k++) ram[16 + k] = 32'(k * k + 1);

    // Reset state
    repeat (2) tick();
    check("rst_halt", halt_req, 0);
    check("rst_valid", dump_valid, 0);
    check("rst_done", done, 0);
    check("rst_rden", mem_rd_en, 0);
    check("rst_cyc", cyc_cnt, 0);
    check("rst_done0", done0, 0);

    // Program run: pc 0..48, three fetch stalls, two flushes, one branch stall
    reset = 1'b1;
    for (int i = 0; i < 13; i++) begin
      pc          = 32'(i * 4);
      stallf      = (i == 2 || i == 5 || i == 9);
      flushe      = (i == 3 || i == 7);
      branchstall = (i == 6);
      tick();
      check("run_halt_low", halt_req, 0);
    end
    pc = 32'd52; stallf = 1'b0; flushe = 1'b0; branchstall = 1'b0;
    tick();
    check("halt_rise", halt_req, 1);
    check("first_rden", mem_rd_en, 1);
    check("cyc_cnt", cyc_cnt, PERF ? 14 : 0);
    check("stall_cnt", stall_cnt, PERF ? 3 : 0);
    check("flush_cnt", flush_cnt, PERF ? 2 : 0);
    check("bstall_cnt", bstall_cnt, PERF ? 1 : 0);

    // pc drop and hazard activity after detection must be ignored
    pc = 32'd0; stallf = 1'b1; flushe = 1'b1;

    for (int k = 0; k < 15; k++) begin
      exp_q.push_back({8'(k), 32'(k * k + 1)});
      addr_q.push_back(8'(16 + k));
    end

    dump_ready = 1'b1;
    pulses = 0;
    held = 1'b0;
    for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
      if (mem_rd_en) begin
        pulses++;
        if (addr_q.size() > 0) check("rd_addr", mem_rd_addr, addr_q.pop_front());
        else check("rd_extra", 1, 0);
      end
      if (dump_valid) begin
        if (dump_index == 8'd3 && !held) begin
          held = 1'b1;
          dump_ready = 1'b0;
          repeat (5) begin
            tick();
            check("hold_valid", dump_valid, 1);
            check("hold_data", dump_data, 10);
            check("hold_index", dump_index, 3);
          end
          dump_ready = 1'b1;
        end
        e = exp_q.pop_front();
        check("dump_index", dump_index, e[39:32]);
        check("dump_data", dump_data, e[31:0]);
      end
      tick();
    end
    check("dump_timeout", exp_q.size(), 0);
    check("rd_pulses", pulses, 15);
    check("done_after_last", done, 1);
    check("valid_after_last", dump_valid, 0);
    check("halt_sticky", halt_req, 1);
    check("cyc_frozen", cyc_cnt, PERF ? 14 : 0);
    check("stall_frozen", stall_cnt, PERF ? 3 : 0);
    repeat (4) tick();
    check("done_sticky", done, 1);
    check("valid_stays_low", dump_valid, 0);

    // Second run, reset asserted during SEND of word 7
    stallf = 1'b0; flushe = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    pc = 32'd52;
    dump_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (dump_valid && dump_index == 8'd7) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("reach_word7", found, 1);
    check("word7_data", dump_data, 50);
    dump_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", dump_valid, 0);
    check("mid_rst_halt", halt_req, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_rden", mem_rd_en, 0);
    check("mid_rst_index", dump_index, 0);
    check("mid_rst_data", dump_data, 0);
    check("mid_rst_addr", mem_rd_addr, 0);
    check("mid_rst_cyc", cyc_cnt, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    pc = 32'd8;
    stallf = 1'b1;
    repeat (3) tick();
    check("restart_halt", halt_req, 0);
    check("restart_valid", dump_valid, 0);
    check("restart_cyc", cyc_cnt, PERF ? 3 : 0);
    check("restart_stall", stall_cnt, PERF ? 3 : 0);
    stallf = 1'b0;

    // Empty dump and 4-bit counter saturation
    reset0 = 1'b1;
    pc0 = 32'd40;
    repeat (20) tick();
    check("sat_cyc", cyc_cnt0, PERF ? 15 : 0);
    check("sat_halt_low", halt_req0, 0);
    pc0 = 32'd52;
    tick();
    check("zero_done", done0, 1);
    check("zero_halt", halt_req0, 1);
    check("zero_valid", dump_valid0, 0);
    check("sat_hold", cyc_cnt0, PERF ? 15 : 0);
    pc0 = 32'd0;
    repeat (4) tick();
    check("zero_done_sticky", done0, 1);
    check("zero_no_rden", saw_rd0, 0);
    check("zero_no_valid", saw_valid0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_monitor_dump.md
Name: pipe_monitor_dump

Overview:
- Synthesizable end-of-program monitor for the pipelined MIPS core.
- Counts cycles, fetch stalls, execute flushes and branch stalls while the program runs.
- Once PC reaches a parametrised end address, it raises a halt request and walks a window of data memory.
- Each word is emitted on a valid/ready stream. Bench or UART logic reads results without hierarchical peeks.

Parameters:
- END_PC, 52: byte PC at or above which the program is considered finished (unsigned compare).
- DUMP_BASE, 16: first data-memory word index to dump.
- DUMP_COUNT, 15: number of words to dump; 0 is legal.
- DATA_W, 32: data word width.
- ADDR_W, 8: data-memory word-address width.
- CNT_W, 32: performance counter width.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc  in  32  fetch-stage PC.
- stallf  in  1  fetch stall from hazard unit.
- flushe  in  1  execute flush from hazard unit.
- branchstall  in  1  branch-compare stall from hazard unit.
- halt_req  out  1  request to freeze the core; sticky until reset.
- mem_rd_en  out  1  data-memory read strobe.
- mem_rd_addr  out  ADDR_W  word address, DUMP_BASE+idx.
- mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
- dump_valid  out  1  dump word available.
- dump_ready  in  1  consumer accepts word.
- dump_index  out  8  offset of current word (0..DUMP_COUNT-1).
- dump_data  out  DATA_W  current word.
- done  out  1  dump complete; sticky until reset.
- cyc_cnt  out  CNT_W  cycles spent in RUN.
- stall_cnt  out  CNT_W  cycles with stallf=1 in RUN.
- flush_cnt  out  CNT_W  cycles with flushe=1 in RUN.
- bstall_cnt  out  CNT_W  cycles with branchstall=1 in RUN.

Behaviour:
- Reset (reset=0, async): state=RUN; idx=0; all outputs and counters are 0.
- FSM states: RUN, REQ, WAIT, SEND, DONE.
- RUN:
  - Each cycle, cyc_cnt increments, and each other counter increments when its input is 1.
  - All counters saturate at all-ones and do not wrap.
  - If pc>=END_PC, the next state is REQ when DUMP_COUNT>0, else DONE.
  - halt_req=1 from that next cycle onward.
  - The counter update in the detect cycle is included; counters freeze after it.
- REQ: mem_rd_en=1, mem_rd_addr=DUMP_BASE+idx (truncated to ADDR_W, wraps modulo 2^ADDR_W) -> WAIT.
- WAIT: capture mem_rd_data into the dump_data register -> SEND.
- SEND:
  - dump_valid=1; dump_data and dump_index stay stable until the handshake.
  - Handshake = dump_valid & dump_ready in the same cycle.
  - On handshake: if idx==DUMP_COUNT-1, go to DONE; else idx+1 and go to REQ.
  - Minimum of 3 cycles per word.
- DONE: done=1, halt_req=1, dump_valid=0; held until reset.
- pc is ignored outside RUN; a later drop of pc below END_PC has no effect.
- Hazard inputs are ignored outside RUN.
- Reset asserted mid-dump aborts immediately. All state returns to reset values; no partial handshake is required.
- dump_ready is ignored when dump_valid=0.
- mem_rd_en is a single-cycle pulse per word.

Optional Feature:
- Macro: PIPE_MON_PERF_EN.
- Defined: the four counters are implemented as above.
- Undefined: no counter flops are built; cyc_cnt, stall_cnt, flush_cnt and bstall_cnt are tied to 0. FSM and dump behaviour are unchanged.

Test Plan:
- Release reset. Drive pc 0,4,...,48 for 13 cycles with stallf=1 on 3 of them and flushe=1 on 2, then pc=52 -> halt_req rises the next cycle. cyc_cnt=14, stall_cnt=3, flush_cnt=2; counters then frozen.
- Model RAM[16+k]=k*k+1 and hold dump_ready=1 -> 15 words with index 0..14 and data 1,2,5,...,197. mem_rd_addr 16..30; done asserts after the last handshake.
- Hold dump_ready=0 for 5 cycles during word 3 -> dump_valid stays 1, dump_data stays 10 and dump_index stays 3; exactly one transfer on release.
- DUMP_COUNT=0, pc=52 -> state goes straight to DONE; done=1, no mem_rd_en pulse, dump_valid never asserted.
- Assert reset during the SEND of word 7 -> all outputs are 0 within the same cycle. After release with pc<52, the FSM is in RUN and counters restart from 0.
- Force cyc_cnt near all-ones (CNT_W=4), run 20 cycles in RUN -> cyc_cnt holds at 15.
